// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  // Loader sequencing states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_VERIFY = 3'd2,
    ST_RUN    = 3'd3,
    ST_ERR    = 3'd4
  } loader_state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_CNT_W     = 16;

  // Little-endian byte lane k of a 32-bit word (4:1 mux)
  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/imem_boot_loader.sv
// Boot loader: accepts 32-bit words on a valid/ready stream, writes each as four
// little-endian byte writes into the byte-wide instruction memory at
// load_addr + BASE_OFFSET, and holds the core in reset-like idle (start=0) until
// the word tagged load_last is committed.
// Optional feature macro: LOADER_VERIFY_EN adds a 4-cycle read-back VERIFY phase
// per word; any read-back mismatch drives the loader into the sticky error state.
// All outputs are registers loaded from the next-state decode, so they change
// on the same edge as the state they describe.
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned BASE_OFFSET = 4,
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [31:0]           load_word,
  input  logic [ADDR_W-1:0]     load_addr,
  input  logic                  load_last,
  input  logic                  reload,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  output logic                  start,
  output logic                  done,
  output logic                  error,
  output logic [WORD_CNT_W-1:0] word_count
);

  // Bounds arithmetic is one bit wider than the address so a wrapping
  // address can never look in range.
  localparam logic [ADDR_W:0]       END_PAD = (ADDR_W+1)'(BASE_OFFSET + BYTES_PER_WORD - 1);
  localparam logic [ADDR_W:0]       LIMIT   = (ADDR_W+1)'(DEPTH_BYTES);
  localparam logic [ADDR_W-1:0]     OFFSET  = ADDR_W'(BASE_OFFSET);
  localparam logic [WORD_CNT_W-1:0] CNT_MAX = {WORD_CNT_W{1'b1}};

  loader_state_e         state_r, state_s;
  logic [1:0]            k_r, k_s;
  logic [31:0]           word_r;
  logic [ADDR_W-1:0]     addr_r;
  logic                  last_r;

  logic                  accept_s;
  logic                  addr_ok_s;
  logic [ADDR_W:0]       span_end_s;
  logic [ADDR_W-1:0]     base_s;
  logic [31:0]           src_word_s;
  logic                  commit_s;
  logic                  clear_cnt_s;

  logic                  ready_s;
  logic                  we_s;
  logic [ADDR_W-1:0]     maddr_s;
  logic [7:0]            wdata_s;
  logic [WORD_CNT_W-1:0] count_s;

  assign accept_s   = load_valid && load_ready;
  assign span_end_s = {1'b0, load_addr} + END_PAD;
  assign addr_ok_s  = (load_addr[1:0] == 2'b00) && (span_end_s < LIMIT);
  assign base_s     = accept_s ? (load_addr + OFFSET) : addr_r;
  assign src_word_s = accept_s ? load_word : word_r;

`ifndef LOADER_VERIFY_EN
  logic unused_rdata_s;
  assign unused_rdata_s = ^mem_rdata;
`endif

  // Next-state logic: byte sequencing, verify, commit and reload handling
  always_comb begin
    state_s     = state_r;
    k_s         = k_r;
    commit_s    = 1'b0;
    clear_cnt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          k_s     = 2'd0;
          state_s = addr_ok_s ? ST_WRITE : ST_ERR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (k_r == 2'd3) begin
`ifdef LOADER_VERIFY_EN
          k_s     = 2'd0;
          state_s = ST_VERIFY;
`else
          commit_s = 1'b1;
          state_s  = last_r ? ST_RUN : ST_IDLE;
`endif
        end else begin
          k_s = k_r + 2'd1;
        end
      end
      ST_VERIFY: begin
`ifdef LOADER_VERIFY_EN
        if (mem_rdata != byte_lane(word_r, k_r)) begin
          state_s = ST_ERR;
        end else if (k_r == 2'd3) begin
          commit_s = 1'b1;
          state_s  = last_r ? ST_RUN : ST_IDLE;
        end else begin
          k_s = k_r + 2'd1;
        end
`else
        state_s = ST_ERR;
`endif
      end
      ST_RUN: begin
        if (reload) begin
          clear_cnt_s = 1'b1;
          state_s     = ST_IDLE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_ERR: begin
        if (reload) begin
          clear_cnt_s = 1'b1;
          state_s     = ST_IDLE;
        end else begin
          state_s = ST_ERR;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state, loaded into the output registers
  always_comb begin
    ready_s = (state_s == ST_IDLE);
    we_s    = (state_s == ST_WRITE);
    maddr_s = {ADDR_W{1'b0}};
    wdata_s = 8'h00;
    count_s = word_count;
    if ((state_s == ST_WRITE) || (state_s == ST_VERIFY)) begin
      maddr_s = base_s + ADDR_W'(k_s);
    end else begin
      maddr_s = {ADDR_W{1'b0}};
    end
    if (we_s) begin
      wdata_s = byte_lane(src_word_s, k_s);
    end else begin
      wdata_s = 8'h00;
    end
    if (clear_cnt_s) begin
      count_s = {WORD_CNT_W{1'b0}};
    end else if (commit_s && (word_count != CNT_MAX)) begin
      count_s = word_count + {{(WORD_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_s = word_count;
    end
  end

  // State, byte index and latched word/address/last registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      k_r     <= 2'd0;
      word_r  <= 32'h0000_0000;
      addr_r  <= {ADDR_W{1'b0}};
      last_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      k_r     <= k_s;
      if (accept_s) begin
        word_r <= load_word;
        addr_r <= load_addr + OFFSET;
        last_r <= load_last;
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      load_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= {ADDR_W{1'b0}};
      mem_wdata  <= 8'h00;
      start      <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= {WORD_CNT_W{1'b0}};
    end else begin
      load_ready <= ready_s;
      mem_we     <= we_s;
      mem_addr   <= maddr_s;
      mem_wdata  <= wdata_s;
      start      <= (state_s == ST_RUN);
      done       <= (state_s == ST_RUN);
      error      <= (state_s == ST_ERR);
      word_count <= count_s;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader with a byte-wide memory model.
// Build with +define+LOADER_VERIFY_EN to exercise the read-back verify phase.
module tb_imem_boot_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [31:0] load_word = 32'h0;
  logic [31:0] load_addr = 32'h0;
  logic        load_last = 1'b0;
  logic        reload = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        start;
  logic        done;
  logic        error;
  logic [15:0] word_count;

  logic [7:0]  imem [0:1023];
  logic        corrupt = 1'b0;
  logic [31:0] corrupt_addr = 32'h0;

  int passes = 0;
  int checks = 0;

`ifdef LOADER_VERIFY_EN
  localparam int WORD_CYCLES = 9;
`else
  localparam int WORD_CYCLES = 5;
`endif

  imem_boot_loader #(.BASE_OFFSET(4), .DEPTH_BYTES(1024), .ADDR_W(32)) dut (
    .clock(clock), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready), .load_word(load_word),
    .load_addr(load_addr), .load_last(load_last), .reload(reload),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .start(start), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clock = ~clock;

  // Byte-wide instruction memory model
  always @(posedge clock) begin
    if (mem_we && (mem_addr < 32'd1024)) imem[mem_addr[9:0]] <= mem_wdata;
  end

  assign mem_rdata = ((mem_addr < 32'd1024) ? imem[mem_addr[9:0]] : 8'h00)
                     ^ ((corrupt && (mem_addr == corrupt_addr)) ? 8'hFF : 8'h00);

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] a, input logic l);
    int n = 0;
    while (load_ready !== 1'b1 && n < 50) begin step(); n++; end
    if (load_ready !== 1'b1) begin
      checks++; $display("FAIL send_timeout: load_ready=%b required 1", load_ready);
    end
    load_word = w; load_addr = a; load_last = l; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(load_ready === 1'b1 || start === 1'b1 || error === 1'b1) && n < 40) begin step(); n++; end
    if (n >= 40) begin
      checks++; $display("FAIL wait_idle_timeout: no idle/run/error after %0d cycles", n);
    end
  endtask

  task automatic pulse_reload();
    reload = 1'b1; step(); reload = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; #1;
    checks++; if ({load_ready, mem_we, start, done, error} !== 5'b0) $display("FAIL reset_flags: got %b required 00000", {load_ready, mem_we, start, done, error}); else passes++;
    checks++; if ({word_count, mem_addr, mem_wdata} !== 56'h0) $display("FAIL reset_buses: got %h required 0", {word_count, mem_addr, mem_wdata}); else passes++;
    step(); step();
    reset = 1'b1;
    step();
    checks++; if (load_ready !== 1'b1) $display("FAIL reset_ready_after: got %b required 1", load_ready); else passes++;
  endtask

  task automatic test_single_word();
    logic [7:0] exp_b [4];
    exp_b = '{8'h93, 8'h0f, 8'h00, 8'h01};
    send_word(32'h01000f93, 32'h0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({mem_we, mem_addr, mem_wdata, start} !== {1'b1, 32'(4 + k), exp_b[k], 1'b0})
        $display("FAIL single_byte%0d: we=%b addr=%0d data=%h start=%b required 1/%0d/%h/0", k, mem_we, mem_addr, mem_wdata, start, 4 + k, exp_b[k]);
      else passes++;
      step();
    end
`ifdef LOADER_VERIFY_EN
    repeat (4) step();
`endif
    checks++; if ({start, done, mem_we, word_count} !== {3'b110, 16'd1}) $display("FAIL single_commit: start=%b done=%b we=%b count=%0d required 1/1/0/1", start, done, mem_we, word_count); else passes++;
    checks++; if ({imem[7], imem[6], imem[5], imem[4]} !== 32'h01000f93) $display("FAIL single_mem: got %h required 01000f93", {imem[7], imem[6], imem[5], imem[4]}); else passes++;
    pulse_reload();
    checks++; if ({start, done, load_ready, word_count} !== {3'b001, 16'd0}) $display("FAIL reload_clear: start=%b done=%b ready=%b count=%0d required 0/0/1/0", start, done, load_ready, word_count); else passes++;
  endtask

  task automatic test_program();
    logic [31:0] prog [7];
    prog = '{32'h00100093, 32'h00200113, 32'h002081b3, 32'h40208233,
             32'h00402023, 32'hdeadbeef, 32'h0000006f};
    for (int i = 0; i < 7; i++) begin
      send_word(prog[i], 32'(i * 4), (i == 6));
      wait_idle();
      if (i == 5) begin
        checks++; if ({start, word_count} !== {1'b0, 16'd6}) $display("FAIL prog_before_last: start=%b count=%0d required 0/6", start, word_count); else passes++;
      end
    end
    checks++; if ({start, done, word_count} !== {2'b11, 16'd7}) $display("FAIL prog_run: start=%b done=%b count=%0d required 1/1/7", start, done, word_count); else passes++;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if ({imem[4*i+7], imem[4*i+6], imem[4*i+5], imem[4*i+4]} !== prog[i])
        $display("FAIL prog_mem%0d: got %h required %h", i, {imem[4*i+7], imem[4*i+6], imem[4*i+5], imem[4*i+4]}, prog[i]);
      else passes++;
    end
  endtask

  task automatic test_misaligned();
    pulse_reload();
    send_word(32'h12345678, 32'h2, 1'b1);
    checks++; if ({error, mem_we, start, load_ready} !== 4'b1000) $display("FAIL misaligned_err: err=%b we=%b start=%b ready=%b required 1000", error, mem_we, start, load_ready); else passes++;
    step();
    checks++; if ({error, mem_we, start} !== 3'b100) $display("FAIL misaligned_hold: err=%b we=%b start=%b required 100", error, mem_we, start); else passes++;
    pulse_reload();
    checks++; if ({error, load_ready} !== 2'b01) $display("FAIL misaligned_reload: err=%b ready=%b required 01", error, load_ready); else passes++;
  endtask

  task automatic test_bounds();
    send_word(32'hAABBCCDD, 32'd1020, 1'b1);
    checks++; if ({error, mem_we} !== 2'b10) $display("FAIL bounds_1020: err=%b we=%b required 10", error, mem_we); else passes++;
    pulse_reload();
    send_word(32'hAABBCCDD, 32'd1016, 1'b1);
    checks++; if ({error, mem_we, mem_addr, mem_wdata} !== {2'b01, 32'd1020, 8'hDD}) $display("FAIL bounds_1016_first: err=%b we=%b addr=%0d data=%h required 0/1/1020/dd", error, mem_we, mem_addr, mem_wdata); else passes++;
    wait_idle();
    checks++; if ({start, error, word_count, imem[1023]} !== {2'b10, 16'd1, 8'hAA}) $display("FAIL bounds_1016_done: start=%b err=%b count=%0d top=%h required 1/0/1/aa", start, error, word_count, imem[1023]); else passes++;
    pulse_reload();
  endtask

  task automatic test_reset_mid_write();
    send_word(32'hCAFEBABE, 32'd8, 1'b1);
    step(); step();
    #2 reset = 1'b0; #1;
    checks++; if ({load_ready, mem_we, start, done, error, word_count, mem_addr, mem_wdata} !== 61'h0) $display("FAIL midwrite_reset: got %h required 0", {load_ready, mem_we, start, done, error, word_count, mem_addr, mem_wdata}); else passes++;
    step();
    reset = 1'b1;
    send_word(32'hCAFEBABE, 32'd8, 1'b1);
    wait_idle();
    checks++; if ({start, word_count} !== {1'b1, 16'd1}) $display("FAIL midwrite_redo: start=%b count=%0d required 1/1", start, word_count); else passes++;
    checks++; if ({imem[15], imem[14], imem[13], imem[12]} !== 32'hCAFEBABE) $display("FAIL midwrite_mem: got %h required cafebabe", {imem[15], imem[14], imem[13], imem[12]}); else passes++;
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int we_hits = 0;
    pulse_reload();
    send_word(32'h11111111, 32'd36, 1'b0);
    load_word = 32'h87654321; load_addr = 32'd40; load_last = 1'b1; load_valid = 1'b1;
    while (start !== 1'b1 && n < 40) begin step(); n++; end
    checks++; if (n !== 2 * WORD_CYCLES - 1) $display("FAIL b2b_cycles: got %0d edges required %0d", n, 2 * WORD_CYCLES - 1); else passes++;
    checks++; if (word_count !== 16'd2) $display("FAIL b2b_count: got %0d required 2", word_count); else passes++;
    checks++; if ({imem[47], imem[46], imem[45], imem[44], imem[43], imem[40]} !== 48'h876543211111) $display("FAIL b2b_mem: got %h required 876543211111", {imem[47], imem[46], imem[45], imem[44], imem[43], imem[40]}); else passes++;
    for (int i = 0; i < 3; i++) begin
      step();
      if (mem_we === 1'b1) we_hits++;
    end
    checks++; if ({we_hits, word_count, start} !== {32'd0, 16'd2, 1'b1}) $display("FAIL run_ignores_valid: we_hits=%0d count=%0d start=%b required 0/2/1", we_hits, word_count, start); else passes++;
    load_valid = 1'b0;
  endtask

`ifdef LOADER_VERIFY_EN
  task automatic test_verify();
    int n = 0;
    pulse_reload();
    corrupt = 1'b1; corrupt_addr = 32'd6;
    send_word(32'h11223344, 32'd0, 1'b1);
    wait_idle();
    checks++; if ({error, start, word_count} !== {2'b10, 16'd0}) $display("FAIL verify_corrupt: err=%b start=%b count=%0d required 1/0/0", error, start, word_count); else passes++;
    pulse_reload();
    corrupt = 1'b0;
    send_word(32'h11223344, 32'd0, 1'b1);
    n = 1;
    while (start !== 1'b1 && n < 40) begin step(); n++; end
    checks++; if ({n, word_count, error} !== {32'd9, 16'd1, 1'b0}) $display("FAIL verify_clean: edges=%0d count=%0d err=%b required 9/1/0", n, word_count, error); else passes++;
  endtask
`endif

  initial begin
    #2;
    test_reset();
    test_single_word();
    test_program();
    test_misaligned();
    test_bounds();
    test_reset_mid_write();
    test_back_to_back();
`ifdef LOADER_VERIFY_EN
    test_verify();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
